// File: rtl/synth_pkg.sv
// Shared constants, FSM encoding and helpers for the synth square-wave analyzer.
package synth_pkg;

    localparam int unsigned CLOCK_FREQUENCY = 32'd50000000;
    localparam int unsigned TIMEOUT_CYCLES  = 32'd100000001;

    localparam int CNT_W       = 27;
    localparam int DIV_LATENCY = 27;
    localparam int ITER_W      = 5;
    localparam int FREQ_W      = 16;
    localparam int AMP_W       = 6;
    localparam int WAVE_W      = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DIVIDE  = 2'd2
    } analyzer_state_t;

    // Clamp a full-width quotient into the 16-bit frequency code.
    function automatic logic [FREQ_W-1:0] saturate_quotient(input logic [CNT_W-1:0] q);
        logic [FREQ_W-1:0] result;
        if (|q[CNT_W-1:FREQ_W]) begin
            result = {FREQ_W{1'b1}};
        end else begin
            result = q[FREQ_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/period_divider.sv
// Restoring divider: one quotient bit per clock, saturated 16-bit result with a done pulse.
module period_divider
    import synth_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              abort,
    input  logic              start,
    input  logic [CNT_W-1:0]  dividend,
    input  logic [CNT_W-1:0]  divisor,
    output logic              busy,
    output logic              done,
    output logic [FREQ_W-1:0] quotient
);

    logic [CNT_W-1:0]  rem_r;
    logic [CNT_W-1:0]  quo_r;
    logic [CNT_W-1:0]  div_r;
    logic [ITER_W-1:0] iter_r;
    logic              busy_r;
    logic              done_r;
    logic [FREQ_W-1:0] quotient_r;

    logic [CNT_W:0]    shifted_s;
    logic [CNT_W:0]    trial_s;
    logic              fits_s;
    logic [CNT_W-1:0]  quo_next_s;

    // Trial subtraction for the current bit; a clear MSB means the divisor fits.
    always_comb begin
        shifted_s  = {rem_r, quo_r[CNT_W-1]};
        trial_s    = shifted_s - {1'b0, div_r};
        fits_s     = ~trial_s[CNT_W];
        quo_next_s = {quo_r[CNT_W-2:0], fits_s};
    end

    // Iteration state; abort drops an in-flight division without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rem_r      <= '0;
            quo_r      <= '0;
            div_r      <= '0;
            iter_r     <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            quotient_r <= '0;
        end else if (abort) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            iter_r <= '0;
        end else if (start && !busy_r) begin
            rem_r  <= '0;
            quo_r  <= dividend;
            div_r  <= divisor;
            iter_r <= ITER_W'(DIV_LATENCY);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r  <= fits_s ? trial_s[CNT_W-1:0] : shifted_s[CNT_W-1:0];
            quo_r  <= quo_next_s;
            iter_r <= iter_r - 5'd1;
            if (iter_r == 5'd1) begin
                busy_r     <= 1'b0;
                done_r     <= 1'b1;
                quotient_r <= saturate_quotient(quo_next_s);
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = quotient_r;

endmodule

// File: rtl/square_wave_analyzer.sv
// Measures period and high level of the synth tone stream and reports
// frequency code (2*Fclk/P) and 0-to-peak amplitude with a valid pulse.
module square_wave_analyzer
    import synth_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = synth_pkg::CLOCK_FREQUENCY,
    parameter int unsigned TIMEOUT_CYCLES  = synth_pkg::TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WAVE_W-1:0] sq_wave,
    output logic [FREQ_W-1:0] frequency,
    output logic [AMP_W-1:0]  amplitude,
    output logic              valid,
    output logic              busy
);

    localparam logic [CNT_W-1:0] DIVIDEND    = CNT_W'(2 * CLOCK_FREQUENCY);
    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES);

    analyzer_state_t   state_r;
    analyzer_state_t   state_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_s;
    logic [WAVE_W-1:0] prev_r;
    logic [AMP_W-1:0]  pend_amp_r;
    logic [FREQ_W-1:0] freq_r;
    logic [AMP_W-1:0]  amp_r;
    logic              valid_r;

    logic              rise_s;
    logic              start_s;
    logic              timeout_s;
    logic              div_busy_s;
    logic              div_done_s;
    logic [FREQ_W-1:0] div_quot_s;

    assign rise_s = (prev_r == 7'd0) && (sq_wave != 7'd0);

    period_divider u_divider (
        .clk      (clk),
        .reset    (reset),
        .abort    (timeout_s),
        .start    (start_s),
        .dividend (DIVIDEND),
        .divisor  (count_r),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quot_s)
    );

    // Next-state logic: the period counter keeps running while a division is in flight.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        start_s   = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_s = ST_MEASURE;
                    count_s = 27'd1;
                end else begin
                    count_s = 27'd0;
                end
            end
            ST_MEASURE, ST_DIVIDE: begin
                if (rise_s) begin
                    count_s = 27'd1;
                    if (!div_busy_s) begin
                        start_s = 1'b1;
                        state_s = ST_DIVIDE;
                    end else begin
                        state_s = state_r;
                    end
                end else if (count_r >= TIMEOUT_LIM) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                    count_s   = 27'd0;
                end else begin
                    count_s = count_r + 27'd1;
                    if (div_done_s) begin
                        state_s = ST_MEASURE;
                    end else begin
                        state_s = state_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                count_s = 27'd0;
            end
        endcase
    end

    // FSM state, period counter, input history and the amplitude captured at the measuring edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            count_r    <= '0;
            prev_r     <= '0;
            pend_amp_r <= '0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            prev_r  <= sq_wave;
            if (start_s) begin
                pend_amp_r <= sq_wave[WAVE_W-1:1];
            end else begin
                pend_amp_r <= pend_amp_r;
            end
        end
    end

    // Result registers; a timeout outranks a division finishing on the same clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            freq_r  <= '0;
            amp_r   <= '0;
            valid_r <= 1'b0;
        end else if (timeout_s) begin
            freq_r  <= '0;
            amp_r   <= '0;
            valid_r <= 1'b1;
        end else if (div_done_s && (state_r == ST_DIVIDE)) begin
            freq_r  <= div_quot_s;
            amp_r   <= pend_amp_r;
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign frequency = freq_r;
    assign amplitude = amp_r;
    assign valid     = valid_r;
    assign busy      = div_busy_s;

endmodule
